// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: turns m_clk rising edges into ticks and shifts out
// 8-bit frames LSB first with optional parity and one or two stop bits.
module uart_tx_serializer #(
  parameter int unsigned TICKS_PER_BIT = 16,
  parameter bit          PARITY_EN     = 1'b0,
  parameter bit          PARITY_ODD    = 1'b0,
  parameter int unsigned STOP_BITS     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m_clk,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CntW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICKS_PER_BIT - 1);
  localparam logic [2:0] StopLast = (STOP_BITS == 2) ? 3'd1 : 3'd0;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic            r_m_clk_d;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_idx_d;
  logic [7:0]      r_shreg;
  logic [7:0]      w_shreg_d;
  logic            r_parity;
  logic            w_parity_d;
  logic            r_tx;
  logic            w_tx_d;
  logic            r_busy;
  logic            w_busy_d;
  logic            w_tick;
  logic            w_bit_end;

  assign w_tick    = m_clk & ~r_m_clk_d;
  assign w_bit_end = w_tick & (r_cnt == CntLast);

  // r_m_clk_d resets high so a high m_clk right after reset is not seen as an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_m_clk_d <= 1'b1;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_m_clk_d <= m_clk;
      r_cnt     <= w_cnt_d;
      r_bit_idx <= w_bit_idx_d;
      r_shreg   <= w_shreg_d;
      r_parity  <= w_parity_d;
      r_tx      <= w_tx_d;
      r_busy    <= w_busy_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_bit_idx_d = r_bit_idx;
    w_shreg_d   = r_shreg;
    w_parity_d  = r_parity;
    w_tx_d      = r_tx;

    if (r_state != StIdle && w_tick) begin
      w_cnt_d = w_bit_end ? '0 : r_cnt + 1'b1;
    end

    unique case (r_state)
      StIdle: begin
        if (tx_valid) begin
          w_state_d   = StStart;
          w_shreg_d   = tx_data;
          w_parity_d  = ^tx_data ^ PARITY_ODD;
          w_cnt_d     = '0;
          w_bit_idx_d = '0;
          w_tx_d      = 1'b0;
        end
      end
      StStart: begin
        if (w_bit_end) begin
          w_state_d   = StData;
          w_bit_idx_d = '0;
          w_tx_d      = r_shreg[0];
        end
      end
      StData: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_d = '0;
            if (PARITY_EN) begin
              w_state_d = StParity;
              w_tx_d    = r_parity;
            end else begin
              w_state_d = StStop;
              w_tx_d    = 1'b1;
            end
          end else begin
            w_shreg_d   = r_shreg >> 1;
            w_tx_d      = r_shreg[1];
            w_bit_idx_d = r_bit_idx + 3'd1;
          end
        end
      end
      StParity: begin
        if (w_bit_end) begin
          w_state_d   = StStop;
          w_bit_idx_d = '0;
          w_tx_d      = 1'b1;
        end
      end
      StStop: begin
        // Leaving on the last stop tick lets the next frame start with no idle gap.
        if (w_bit_end) begin
          if (r_bit_idx == StopLast) begin
            w_state_d   = StIdle;
            w_bit_idx_d = '0;
          end else begin
            w_bit_idx_d = r_bit_idx + 3'd1;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_tx_d    = 1'b1;
      end
    endcase

    w_busy_d = (w_state_d != StIdle);
  end

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign tx_ready = ~r_busy;

endmodule
